// File: rtl/sprite_pixel_fetch.sv
// Sprite ROM address generator and three-stage output aligner.
// Beam coordinates in; colour, hit and opaque flags out exactly three clocks later.
module sprite_pixel_fetch #(
    parameter int          SPR_W      = 20,
    parameter int          SPR_H      = 20,
    parameter int          ADDR_W     = 9,
    parameter int          SCALE_LOG2 = 0,
    parameter logic [7:0]  KEY_COLOR  = 8'd255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [10:0]       sprite_x,
    input  logic [10:0]       sprite_y,
    input  logic              h_flip,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic              pix_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic [7:0]        pix_out,
    output logic              sprite_hit,
    output logic              sprite_opaque,
    output logic              out_valid
);

    localparam logic [11:0]       FOOT_W  = 12'(SPR_W << SCALE_LOG2);
    localparam logic [11:0]       FOOT_H  = 12'(SPR_H << SCALE_LOG2);
    localparam logic [ADDR_W-1:0] SPR_W_A = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(SPR_W - 1);

    logic [10:0]       x_lat_q, x_lat_d, y_lat_q, y_lat_d;
    logic              flip_lat_q, flip_lat_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit_d1_q, hit_d1_d, valid_d1_q, valid_d1_d;
    logic              hit_d2_q, hit_d2_d, valid_d2_q, valid_d2_d;
    logic [7:0]        pix_out_q, pix_out_d;
    logic              sprite_hit_q, sprite_hit_d;
    logic              sprite_opaque_q, sprite_opaque_d;
    logic              out_valid_q, out_valid_d;

    logic [11:0]       dx_s, dy_s;
    logic              inside_s;
    logic [ADDR_W-1:0] col_raw_s, col_s, row_s;

    // Offsets are 12-bit two's complement so a sprite hanging past 2047 never wraps onto low hcount.
    always_comb begin
        dx_s      = {1'b0, hcount} - {1'b0, x_lat_q};
        dy_s      = {1'b0, vcount} - {1'b0, y_lat_q};
        inside_s  = pix_valid && !dx_s[11] && !dy_s[11] && (dx_s < FOOT_W) && (dy_s < FOOT_H);
        col_raw_s = ADDR_W'(dx_s >> SCALE_LOG2);
        row_s     = ADDR_W'(dy_s >> SCALE_LOG2);
        col_s     = flip_lat_q ? (COL_MAX - col_raw_s) : col_raw_s;

        x_lat_d    = frame_start ? sprite_x : x_lat_q;
        y_lat_d    = frame_start ? sprite_y : y_lat_q;
        flip_lat_d = frame_start ? h_flip   : flip_lat_q;

        rom_addr_d = inside_s ? (row_s * SPR_W_A + col_s) : {ADDR_W{1'b0}};
        hit_d1_d   = inside_s;
        valid_d1_d = pix_valid;

        hit_d2_d   = hit_d1_q;
        valid_d2_d = valid_d1_q;

        pix_out_d       = hit_d2_q ? rom_q : 8'd0;
        sprite_hit_d    = hit_d2_q;
        sprite_opaque_d = hit_d2_q && (rom_q != KEY_COLOR);
        out_valid_d     = valid_d2_q;
    end

    // Position latch and the three pipeline stages; reset flushes every in-flight pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_lat_q         <= 11'd0;
            y_lat_q         <= 11'd0;
            flip_lat_q      <= 1'b0;
            rom_addr_q      <= {ADDR_W{1'b0}};
            hit_d1_q        <= 1'b0;
            valid_d1_q      <= 1'b0;
            hit_d2_q        <= 1'b0;
            valid_d2_q      <= 1'b0;
            pix_out_q       <= 8'd0;
            sprite_hit_q    <= 1'b0;
            sprite_opaque_q <= 1'b0;
            out_valid_q     <= 1'b0;
        end else begin
            x_lat_q         <= x_lat_d;
            y_lat_q         <= y_lat_d;
            flip_lat_q      <= flip_lat_d;
            rom_addr_q      <= rom_addr_d;
            hit_d1_q        <= hit_d1_d;
            valid_d1_q      <= valid_d1_d;
            hit_d2_q        <= hit_d2_d;
            valid_d2_q      <= valid_d2_d;
            pix_out_q       <= pix_out_d;
            sprite_hit_q    <= sprite_hit_d;
            sprite_opaque_q <= sprite_opaque_d;
            out_valid_q     <= out_valid_d;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign pix_out       = pix_out_q;
    assign sprite_hit    = sprite_hit_q;
    assign sprite_opaque = sprite_opaque_q;
    assign out_valid     = out_valid_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: unscaled and 2x-scaled instances, each fed by a
// registered ROM model whose contents are a fixed function of the address.
module tb_sprite_pixel_fetch;

    logic        clock, reset, frame_start, h_flip, pix_valid;
    logic [10:0] sprite_x, sprite_y, hcount, vcount;

    logic [8:0]  rom_addr0, rom_addr1;
    logic [7:0]  rom_q0, rom_q1, pix_out0, pix_out1;
    logic        hit0, hit1, opq0, opq1, ov0, ov1;

    int n_assert = 0;
    int n_fail   = 0;

    sprite_pixel_fetch u_dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .h_flip(h_flip),
        .hcount(hcount), .vcount(vcount), .pix_valid(pix_valid),
        .rom_addr(rom_addr0), .rom_q(rom_q0), .pix_out(pix_out0),
        .sprite_hit(hit0), .sprite_opaque(opq0), .out_valid(ov0)
    );

    sprite_pixel_fetch #(.SCALE_LOG2(1)) u_dut_s1 (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .h_flip(h_flip),
        .hcount(hcount), .vcount(vcount), .pix_valid(pix_valid),
        .rom_addr(rom_addr1), .rom_q(rom_q1), .pix_out(pix_out1),
        .sprite_hit(hit1), .sprite_opaque(opq1), .out_valid(ov1)
    );

    // Address 0 holds the key colour; e.g. 9 -> 204, 21 -> 208, 39 -> 226, 399 -> 74.
    function automatic logic [7:0] rom_fn(input logic [8:0] a);
        if (a == 9'd0) return 8'd255;
        else           return a[7:0] ^ 8'hC5;
    endfunction

    always_ff @(posedge clock) begin
        rom_q0 <= rom_fn(rom_addr0);
        rom_q1 <= rom_fn(rom_addr1);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input int x, input int y, input bit f);
        sprite_x    = 11'(x);
        sprite_y    = 11'(y);
        h_flip      = f;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // One isolated pixel: address one clock after sampling, outputs three clocks after.
    task automatic probe(input bit sel, input string tag, input int h, input int v,
                         input int exp_addr, input bit exp_hit);
        logic [7:0] ep;
        hcount    = 11'(h);
        vcount    = 11'(v);
        pix_valid = 1'b1;
        tick();
        chk({tag, ".addr"}, 32'(sel ? rom_addr1 : rom_addr0), 32'(exp_addr));
        pix_valid = 1'b0;
        tick();
        tick();
        ep = exp_hit ? rom_fn(9'(exp_addr)) : 8'd0;
        chk({tag, ".hit"}, 32'(sel ? hit1 : hit0), 32'(exp_hit));
        chk({tag, ".pix"}, 32'(sel ? pix_out1 : pix_out0), 32'(ep));
        chk({tag, ".opq"}, 32'(sel ? opq1 : opq0), 32'(exp_hit && ep != 8'd255));
        chk({tag, ".ov"}, 32'(sel ? ov1 : ov0), 32'd1);
    endtask

    initial begin
        int h, ea;
        bit in_s;
        reset = 1'b1; frame_start = 1'b0; h_flip = 1'b0; pix_valid = 1'b0;
        sprite_x = 11'd0; sprite_y = 11'd0; hcount = 11'd0; vcount = 11'd0;
        tick();
        tick();
        chk("rst.addr", 32'(rom_addr0), 32'd0);
        chk("rst.pix", 32'(pix_out0), 32'd0);
        chk("rst.hit", 32'(hit0), 32'd0);
        chk("rst.opq", 32'(opq0), 32'd0);
        chk("rst.ov", 32'(ov0), 32'd0);
        reset = 1'b0;
        tick();

        // Latched position is 0,0 out of reset: (3,2) -> 2*20+3 = 43.
        probe(1'b0, "origin", 3, 2, 43, 1'b1);

        frame(100, 50, 1'b0);
        probe(1'b0, "p100_50", 100, 50, 0, 1'b1);
        probe(1'b0, "p109_50", 109, 50, 9, 1'b1);
        probe(1'b0, "p119_69", 119, 69, 399, 1'b1);
        probe(1'b0, "right", 120, 50, 0, 1'b0);
        probe(1'b0, "left", 99, 50, 0, 1'b0);
        probe(1'b0, "bottom", 100, 70, 0, 1'b0);

        hcount = 11'd105; vcount = 11'd50; pix_valid = 1'b0;
        tick();
        chk("novalid.addr", 32'(rom_addr0), 32'd0);
        tick();
        tick();
        chk("novalid.hit", 32'(hit0), 32'd0);
        chk("novalid.ov", 32'(ov0), 32'd0);

        // Mirrored: col 0 maps to ROM column 19, row 1 -> 39.
        frame(100, 50, 1'b1);
        probe(1'b0, "flip", 100, 51, 39, 1'b1);
        sprite_x = 11'd300;
        h_flip   = 1'b0;
        probe(1'b0, "nolatch", 100, 51, 39, 1'b1);

        // Pixel sampled together with frame_start still sees the old position and flip.
        frame_start = 1'b1; hcount = 11'd100; vcount = 11'd51; pix_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("fs_same.addr", 32'(rom_addr0), 32'd39);
        pix_valid = 1'b0;
        tick();
        tick();
        chk("fs_same.hit", 32'(hit0), 32'd1);
        probe(1'b0, "fs_after_old", 100, 51, 0, 1'b0);
        probe(1'b0, "fs_after_new", 300, 50, 0, 1'b1);

        // Footprint past 2047 must not wrap onto low columns.
        frame(2040, 50, 1'b0);
        probe(1'b0, "edge2040", 2040, 50, 0, 1'b1);
        probe(1'b0, "edge2047", 2047, 50, 7, 1'b1);
        probe(1'b0, "nowrap", 5, 50, 0, 1'b0);

        // 2x scaled instance: (102,52) -> row 1 col 1 = 21; 139 is col 19; 140 is outside.
        frame(100, 50, 1'b0);
        probe(1'b1, "s1_102_52", 102, 52, 21, 1'b1);
        probe(1'b1, "s1_139", 139, 50, 19, 1'b1);
        probe(1'b1, "s1_140", 140, 50, 0, 1'b0);

        // 40-pixel stream across row 5 (hcount 90..129): hits only for 100..119, 3-clock latency.
        for (int k = 0; k < 42; k++) begin
            if (k < 40) begin
                hcount = 11'(90 + k); vcount = 11'd55; pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            tick();
            if (k < 40) begin
                h = 90 + k;
                in_s = (h >= 100) && (h < 120);
                ea = in_s ? (100 + h - 100) : 0;
                chk("stream.addr", 32'(rom_addr0), 32'(ea));
            end
            if (k >= 2) begin
                h = 88 + k;
                in_s = (h >= 100) && (h < 120);
                ea = in_s ? (100 + h - 100) : 0;
                chk("stream.hit", 32'(hit0), 32'(in_s));
                chk("stream.pix", 32'(pix_out0), 32'(in_s ? rom_fn(9'(ea)) : 8'd0));
                chk("stream.ov", 32'(ov0), 32'd1);
            end
        end

        // Fill the pipeline with hits, then reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            hcount = 11'(100 + k); vcount = 11'd55; pix_valid = 1'b1;
            tick();
        end
        chk("pre_rst.hit", 32'(hit0), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst.addr", 32'(rom_addr0), 32'd0);
        chk("midrst.pix", 32'(pix_out0), 32'd0);
        chk("midrst.hit", 32'(hit0), 32'd0);
        chk("midrst.opq", 32'(opq0), 32'd0);
        chk("midrst.ov", 32'(ov0), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        pix_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("postrst.hit", 32'(hit0), 32'd0);
            chk("postrst.ov", 32'(ov0), 32'd0);
        end
        probe(1'b0, "postrst_origin", 3, 2, 43, 1'b1);
        frame(100, 50, 1'b0);
        probe(1'b0, "postrst_p105", 105, 50, 5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
